// File: rtl/lcplc_bit_unpacker.sv
// lcplc_bit_unpacker: receive-side inverse of the LCPLC word packer.
// Takes MSB-first W-bit words and serves right-aligned 0..W bit fields
// through a request/response handshake with a one-cycle response latency.
// Optional feature macro: LCPLC_BIT_UNPACKER_UNDERFLOW_EN adds a sticky
// err_underflow output and lets a short final slice drain with zero fill.
module lcplc_bit_unpacker #(
  parameter  int WORD_WIDTH_LOG = 5,
  localparam int W              = 1 << WORD_WIDTH_LOG,
  localparam int L              = WORD_WIDTH_LOG + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] input_data,
  input  logic         input_valid,
  output logic         input_ready,
  input  logic         input_last,
  input  logic [L-1:0] req_len,
  input  logic         req_flush,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] output_data,
  output logic         output_valid,
  input  logic         output_ready,
`ifdef LCPLC_BIT_UNPACKER_UNDERFLOW_EN
  output logic         err_underflow,
`endif
  output logic         output_last
);

  localparam int BW = 2 * W;
  localparam int CW = WORD_WIDTH_LOG + 2;

  // Buffer keeps the oldest bit at the MSB; bits below cnt are always zero,
  // so appending is a plain OR and short reads are zero-filled for free.
  logic [BW-1:0] shift_buf;
  logic [BW-1:0] buf_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] cnt_take;
  logic [CW-1:0] len_ext;
  logic [CW-1:0] drop;
  logic [CW:0]   top_sh;
  logic [CW:0]   shamt;
  logic [W-1:0]  field;
  logic          lastpend;
  logic          lastpend_next;
  logic          active;
  logic          enough;
  logic          under;
  logic          out_free;
  logic          req_take;
  logic          in_take;
  logic          last_hit;

  // Handshakes, field extraction, then the extraction shift followed by the append
  always_comb begin
    len_ext       = CW'(req_len);
    enough        = (cnt >= len_ext);
    out_free      = !output_valid || output_ready;
`ifdef LCPLC_BIT_UNPACKER_UNDERFLOW_EN
    under         = lastpend && !enough;
`else
    under         = 1'b0;
`endif
    req_ready     = active && req_valid && out_free && (enough || under);
    input_ready   = active && (cnt <= CW'(W)) && !lastpend;
    req_take      = req_ready;
    in_take       = input_valid && input_ready;

    top_sh        = (CW+1)'(BW) - (CW+1)'(req_len);
    field         = W'(shift_buf >> top_sh);

    cnt_take      = cnt - len_ext;
    drop          = '0;
    if (req_flush) begin
      drop = CW'(cnt_take[WORD_WIDTH_LOG-1:0]);
    end
    shamt         = (CW+1)'(len_ext) + (CW+1)'(drop);

    cnt_next      = cnt;
    buf_next      = shift_buf;
    lastpend_next = lastpend;
    last_hit      = 1'b0;

    if (req_take) begin
      if (under) begin
        cnt_next = '0;
        buf_next = '0;
        last_hit = 1'b1;
      end else begin
        cnt_next = cnt_take - drop;
        buf_next = shift_buf << shamt;
        last_hit = lastpend && (cnt_next == '0);
      end
    end
    if (last_hit) begin
      lastpend_next = 1'b0;
    end

    if (in_take) begin
      buf_next = buf_next | ({input_data, {W{1'b0}}} >> cnt_next);
      cnt_next = cnt_next + CW'(W);
      if (input_last) begin
        lastpend_next = 1'b1;
      end
    end
  end

  // Buffer, count and response register; outputs hold while the consumer stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active       <= 1'b0;
      shift_buf    <= '0;
      cnt          <= '0;
      lastpend     <= 1'b0;
      output_data  <= '0;
      output_valid <= 1'b0;
      output_last  <= 1'b0;
    end else begin
      active    <= 1'b1;
      shift_buf <= buf_next;
      cnt       <= cnt_next;
      lastpend  <= lastpend_next;
      if (req_take) begin
        output_data  <= field;
        output_valid <= 1'b1;
        output_last  <= last_hit;
      end else if (output_ready) begin
        output_valid <= 1'b0;
        output_last  <= 1'b0;
      end
    end
  end

`ifdef LCPLC_BIT_UNPACKER_UNDERFLOW_EN
  // Sticky underflow flag, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_underflow <= 1'b0;
    end else if (req_take && under) begin
      err_underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lcplc_bit_unpacker.sv
// Testbench for lcplc_bit_unpacker: directed cases plus a randomized
// multi-slice stream checked against a bit-queue reference model.
module tb_lcplc_bit_unpacker;

  localparam int W        = 32;
  localparam int BOUND    = 2000;
  localparam int SLICES   = 4;
  localparam int SLICE_WD = 250;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_data = '0;
  logic        input_valid = 1'b0;
  logic        input_ready;
  logic        input_last = 1'b0;
  logic [5:0]  req_len = '0;
  logic        req_flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] output_data;
  logic        output_valid;
  logic        output_ready = 1'b1;
  logic        output_last;
`ifdef LCPLC_BIT_UNPACKER_UNDERFLOW_EN
  logic        err_underflow;
`endif

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;
  int last_seen = 0;

  bit          bitq[$];
  logic [32:0] exp_q[$];
  logic        lastpend_m = 1'b0;

  lcplc_bit_unpacker dut (
    .clk          (clk),
    .rst          (rst),
    .input_data   (input_data),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_last   (input_last),
    .req_len      (req_len),
    .req_flush    (req_flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .output_data  (output_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
`ifdef LCPLC_BIT_UNPACKER_UNDERFLOW_EN
    .err_underflow(err_underflow),
`endif
    .output_last  (output_last)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Consumer readiness: 0 = stalled, 1 = always ready, otherwise random
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       output_ready = 1'b0;
        1:       output_ready = 1'b1;
        default: output_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Request lengths above the word width must never be issued
  always @(negedge clk) begin
    if (rst && req_valid) begin
      assert (req_len <= 6'(W)) else $error("[TB] req_len %0d exceeds word width", req_len);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: pull len bits from the bit stream, drop the rest of the head word on flush
  task automatic modelRequest(input int len, input logic fl);
    logic [31:0] v;
    logic        lst;
    v = '0;
    if (bitq.size() >= len) begin
      for (int i = 0; i < len; i++) v = {v[30:0], bitq.pop_front()};
      if (fl) begin
        int n;
        n = bitq.size() % W;
        for (int i = 0; i < n; i++) void'(bitq.pop_front());
      end
    end else begin
      for (int i = 0; i < len; i++) begin
        if (bitq.size() > 0) v = {v[30:0], bitq.pop_front()};
        else v = {v[30:0], 1'b0};
      end
    end
    lst = lastpend_m && (bitq.size() == 0);
    if (lst) lastpend_m = 1'b0;
    exp_q.push_back({lst, v});
  endtask

  // Scoreboard: responses first, then the request (pre-append bits), then the new word
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      bitq.delete();
      lastpend_m = 1'b0;
    end else begin
      if (output_valid && output_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_response", 1, 0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          checkOutput("resp_data", output_data, e[31:0]);
          checkOutput("resp_last", output_last, e[32]);
        end
        if (output_last) last_seen++;
      end
      if (req_valid && req_ready) modelRequest(int'(req_len), req_flush);
      if (input_valid && input_ready) begin
        for (int i = W - 1; i >= 0; i--) bitq.push_back(input_data[i]);
        if (input_last) lastpend_m = 1'b1;
      end
    end
  end

  task automatic applyWord(input logic [31:0] d, input logic l);
    int n;
    input_data  = d;
    input_last  = l;
    input_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!input_ready && n < BOUND);
    if (!input_ready) checkOutput("word_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    input_valid = 1'b0;
    input_last  = 1'b0;
  endtask

  task automatic applyRequest(input int len, input logic fl);
    int n;
    req_len   = 6'(len);
    req_flush = fl;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < BOUND);
    if (!req_ready) checkOutput("req_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_flush = 1'b0;
  endtask

  task automatic waitResponse(input string tag, input logic [31:0] d, input logic l);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(output_valid && output_ready) && n < BOUND);
    if (!(output_valid && output_ready)) begin
      checkOutput({tag, "_timeout"}, 0, 1);
    end else begin
      checkOutput({tag, "_data"}, output_data, d);
      checkOutput({tag, "_last"}, output_last, l);
    end
    @(posedge clk);
    #1;
  endtask

  // Randomized slices: words from a producer, length-bounded requests from a consumer
  task automatic applyStimulus();
    fork
      begin
        for (int s = 0; s < SLICES; s++)
          for (int i = 0; i < SLICE_WD; i++)
            applyWord($urandom, (i == SLICE_WD - 1));
      end
      begin
        for (int s = 0; s < SLICES; s++) begin
          int pos;
          int total;
          pos   = 0;
          total = SLICE_WD * W;
          while (pos < total) begin
            int   len;
            logic fl;
            len = $urandom_range(0, W);
            if (len > total - pos) len = total - pos;
            fl = ($urandom_range(0, 7) == 0);
            applyRequest(len, fl);
            pos += len;
            if (fl) pos += (W - (pos % W)) % W;
          end
        end
      end
    join
  endtask

  initial begin
    int base_last;
    int n;

    begin : watchdog_guard
    end
    // Reset state
    #12;
    checkOutput("reset_output_valid", output_valid, 0);
    checkOutput("reset_output_data", output_data, 0);
    checkOutput("reset_output_last", output_last, 0);
    checkOutput("reset_input_ready", input_ready, 0);
    checkOutput("reset_req_ready", req_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single field with one-cycle latency
    applyWord(32'hA500_0000, 1'b0);
    applyRequest(8, 1'b0);
    @(negedge clk);
    checkOutput("single_latency", output_valid, 1);
    @(posedge clk);
    #1;
    applyRequest(24, 1'b0);
    waitResponse("single_rest", 32'h0, 1'b0);

    // Field straddling a word boundary
    applyWord(32'h0000_000F, 1'b0);
    applyWord(32'hF000_0000, 1'b0);
    applyRequest(28, 1'b0);
    waitResponse("straddle_a", 32'h0, 1'b0);
    applyRequest(8, 1'b0);
    waitResponse("straddle_b", 32'hFF, 1'b0);
    applyRequest(28, 1'b0);
    waitResponse("straddle_c", 32'h0, 1'b0);

    // Flush on the last word
    applyWord(32'hDEAD_BEEF, 1'b1);
    checkOutput("lastpend_blocks_input", input_ready, 0);
    applyRequest(4, 1'b1);
    checkOutput("flush_input_ready_back", input_ready, 1);
    waitResponse("flush", 32'hD, 1'b1);

    // Backpressure: response held, next request stalled
    ready_mode = 0;
    @(posedge clk);
    #1;
    applyWord(32'h1234_5678, 1'b0);
    applyWord(32'h9ABC_DEF0, 1'b0);
    applyRequest(8, 1'b0);
    req_len   = 6'd8;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid", output_valid, 1);
      checkOutput("bp_hold_data", output_data, 32'h12);
      checkOutput("bp_req_stalled", req_ready, 0);
    end
    @(posedge clk);
    #1;
    ready_mode = 1;
    applyRequest(8, 1'b0);
    waitResponse("bp_second", 32'h34, 1'b0);
    applyRequest(32, 1'b0);
    waitResponse("bp_third", 32'h5678_9ABC, 1'b0);
    applyRequest(16, 1'b0);
    waitResponse("bp_fourth", 32'hDEF0, 1'b0);

    // Full buffer and zero-length request
    applyWord(32'h1111_1111, 1'b0);
    applyWord(32'h2222_2222, 1'b0);
    applyRequest(24, 1'b0);
    waitResponse("full_a", 32'h11_1111, 1'b0);
    checkOutput("full_blocks_input", input_ready, 0);
    applyRequest(0, 1'b0);
    waitResponse("zero_len", 32'h0, 1'b0);
    checkOutput("zero_len_still_full", input_ready, 0);
    applyRequest(8, 1'b0);
    waitResponse("full_b", 32'h11, 1'b0);
    checkOutput("full_drained_ready", input_ready, 1);
    applyRequest(32, 1'b0);
    waitResponse("full_c", 32'h2222_2222, 1'b0);

    // Reset while a response is pending
    ready_mode = 0;
    @(posedge clk);
    #1;
    applyWord(32'hCAFE_F00D, 1'b0);
    applyRequest(8, 1'b0);
    checkOutput("pre_reset_valid", output_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset_output_valid", output_valid, 0);
    checkOutput("midreset_output_data", output_data, 0);
    checkOutput("midreset_output_last", output_last, 0);
    checkOutput("midreset_input_ready", input_ready, 0);
    req_len   = 6'd0;
    req_valid = 1'b1;
    #1;
    checkOutput("midreset_req_ready", req_ready, 0);
    req_valid  = 1'b0;
    ready_mode = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    applyWord(32'h8000_0001, 1'b0);
    applyRequest(1, 1'b0);
    waitResponse("post_reset_msb", 32'h1, 1'b0);
    applyRequest(31, 1'b0);
    waitResponse("post_reset_rest", 32'h1, 1'b0);

`ifdef LCPLC_BIT_UNPACKER_UNDERFLOW_EN
    // Short final slice drains with zero fill
    applyWord(32'h0000_0005, 1'b1);
    applyRequest(29, 1'b0);
    waitResponse("underflow_pre", 32'h0, 1'b0);
    checkOutput("underflow_flag_clear", err_underflow, 0);
    applyRequest(8, 1'b0);
    waitResponse("underflow", 32'hA0, 1'b1);
    checkOutput("underflow_flag_set", err_underflow, 1);
`endif

    // Randomized stream against the model
    ready_mode = 2;
    base_last  = last_seen;
    applyStimulus();
    n = 0;
    while (exp_q.size() != 0 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    checkOutput("random_drain", exp_q.size(), 0);
    checkOutput("random_last_count", last_seen - base_last, SLICES);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always ends on its own
  initial begin
    #800000;
    checkOutput("global_timeout", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
